// File: rtl/counter_seq.sv
// Start/limit sequencer around a counter: accepts a terminal value over a
// valid/ready handshake, counts with an optional prescaler, supports pause and abort.
module counter_seq #(
  parameter int WIDTH       = 8,
  parameter int PRESCALE    = 1,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] start_limit,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  // Handshake: a start transfers on a rising edge where start_valid && start_ready;
  // start_ready is high only in IDLE and a refused start_valid is not queued.
  state_t           state, state_next;
  logic [WIDTH-1:0] count_next, limit_q, limit_next, count_inc;
  logic [PW-1:0]    presc, presc_next;
  logic             done_next, aborted_next, tick;

  assign count_inc   = count + WIDTH'(1);
  assign tick        = (presc == PRESC_LAST);
  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      presc   <= '0;
      limit_q <= '0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      presc   <= presc_next;
      limit_q <= limit_next;
      done    <= done_next;
      aborted <= aborted_next;
    end
  end

  always_comb begin
    state_next   = state;
    count_next   = count;
    presc_next   = presc;
    limit_next   = limit_q;
    done_next    = 1'b0;
    aborted_next = 1'b0;
    case (state)
      IDLE: begin
        // abort is ignored here, so a simultaneous start wins
        if (start_valid) begin
          limit_next = start_limit;
          count_next = '0;
          presc_next = '0;
          if (start_limit == '0) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN, PAUSED: begin
        if (abort) begin
          state_next   = IDLE;
          count_next   = '0;
          presc_next   = '0;
          aborted_next = 1'b1;
        end else if (pause) begin
          state_next = PAUSED;
        end else begin
          // The resume edge counts like any RUN edge, so a pause costs exactly its length.
          state_next = RUN;
          if (tick) begin
            presc_next = '0;
            count_next = count_inc;
            if (count_inc == limit_q) begin
              state_next = DONE;
              done_next  = 1'b1;
            end
          end else begin
            presc_next = presc + PW'(1);
          end
        end
      end
      DONE: begin
        if (abort) begin
          state_next   = IDLE;
          count_next   = '0;
          presc_next   = '0;
          aborted_next = 1'b1;
        end else if (AUTO_RELOAD) begin
          state_next = RUN;
          count_next = '0;
          presc_next = '0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
